// File: rtl/stoch_sat_addsub_array.sv
// Array of independent stochastic saturating add/subtract channels.
// Each channel buffers surplus ones in a saturating backlog counter and emits at most one per cycle.
module stoch_sat_addsub_array #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned COUNTER_SIZE = 8,
    parameter int unsigned REG_OUT      = 1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             EN,
    input  logic                             CLR,
    input  logic [NUM_CH-1:0]                MODE,
    input  logic [NUM_CH-1:0]                A,
    input  logic [NUM_CH-1:0]                B,
    output logic [NUM_CH-1:0]                Y,
    output logic [NUM_CH-1:0]                SAT,
    output logic [NUM_CH*COUNTER_SIZE-1:0]   COUNT
);

    localparam int unsigned CW = COUNTER_SIZE;
    localparam int unsigned TW = COUNTER_SIZE + 2;
    localparam logic [TW-1:0] MAX_T = {2'b00, {CW{1'b1}}};

    logic active_c;

    assign active_c = EN & ~CLR & ~RST;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          sat_q;
        logic          hit_c;
        logic          y_raw_c;
        logic [TW-1:0] up_c;
        logic [TW-1:0] t_c;
        logic [TW-1:0] n_c;

        // Backlog arithmetic: floor at zero in subtract mode, clamp the post-emission value at MAX.
        always_comb begin
            up_c    = '0;
            t_c     = '0;
            n_c     = '0;
            y_raw_c = 1'b0;
            hit_c   = 1'b0;
            cnt_d   = '0;

            up_c = TW'(cnt_q) + TW'(A[i]) + (MODE[i] ? TW'(B[i]) : TW'(0));
            if (!MODE[i] && B[i]) begin
                t_c = (up_c == TW'(0)) ? TW'(0) : up_c - TW'(1);
            end else begin
                t_c = up_c;
            end
            y_raw_c = (t_c != TW'(0));
            n_c     = t_c - TW'(y_raw_c);
            hit_c   = (n_c > MAX_T);
            cnt_d   = hit_c ? MAX_T[CW-1:0] : n_c[CW-1:0];
        end

        always_ff @(posedge CLK) begin
            if (RST || CLR) begin
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else if (EN) begin
                cnt_q <= cnt_d;
                sat_q <= sat_q | hit_c;
            end
        end

        if (REG_OUT != 0) begin : g_yreg
            logic y_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    y_q <= 1'b0;
                end else begin
                    y_q <= y_raw_c & active_c;
                end
            end

            assign Y[i] = y_q;
        end else begin : g_ycomb
            assign Y[i] = y_raw_c & active_c;
        end

        assign SAT[i]                    = sat_q;
        assign COUNT[i*CW +: CW]         = cnt_q;
    end

endmodule

// File: tb/tb_stoch_sat_addsub_array.sv
// Bench for stoch_sat_addsub_array: three configurations driven in lockstep against an arithmetic reference.
module tb_stoch_sat_addsub_array;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] mode;
    logic [3:0] a;
    logic [3:0] b;

    logic [3:0]  y_r8,  sat_r8;
    logic [31:0] cnt_r8;
    logic [3:0]  y_c8,  sat_c8;
    logic [31:0] cnt_c8;
    logic [3:0]  y_r2,  sat_r2;
    logic [7:0]  cnt_r2;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: backlog counters, sticky flags and registered outputs as plain integers.
    int m8 [4];
    int m2 [4];
    bit s8 [4];
    bit s2 [4];
    bit yr8[4];
    bit yr2[4];

    stoch_sat_addsub_array #(.NUM_CH(4), .COUNTER_SIZE(8), .REG_OUT(1)) u_r8 (
        .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .MODE(mode), .A(a), .B(b),
        .Y(y_r8), .SAT(sat_r8), .COUNT(cnt_r8));

    stoch_sat_addsub_array #(.NUM_CH(4), .COUNTER_SIZE(8), .REG_OUT(0)) u_c8 (
        .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .MODE(mode), .A(a), .B(b),
        .Y(y_c8), .SAT(sat_c8), .COUNT(cnt_c8));

    stoch_sat_addsub_array #(.NUM_CH(4), .COUNTER_SIZE(2), .REG_OUT(1)) u_r2 (
        .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .MODE(mode), .A(a), .B(b),
        .Y(y_r2), .SAT(sat_r2), .COUNT(cnt_r2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s ch%0d observed=%0d expected=%0d", tag, ch, obs, exp);
        end
    endtask

    // Saturating arithmetic from the rules: value = c + a +/- b, floored at 0, one unit emitted, capped at mx.
    function automatic void calc(input int c, input bit m, input bit ai, input bit bi, input int mx,
                                 output int nc, output bit y, output bit hit);
        int t;
        t = m ? (c + ai + bi) : (c + ai - bi);
        if (t < 0) t = 0;
        y   = (t >= 1);
        nc  = t - int'(y);
        hit = (nc > mx);
        if (hit) nc = mx;
    endfunction

    task automatic drive(input bit r, input bit e, input bit c, input logic [3:0] m,
                         input logic [3:0] ai, input logic [3:0] bi);
        rst = r; en = e; clr = c; mode = m; a = ai; b = bi;
    endtask

    task automatic cycle();
        int  n8[4];
        int  n2[4];
        bit  y8[4];
        bit  y2[4];
        bit  h8[4];
        bit  h2[4];
        bit  act;
        @(negedge clk);
        act = en && !clr && !rst;
        for (int i = 0; i < 4; i++) begin
            calc(m8[i], mode[i], a[i], b[i], 255, n8[i], y8[i], h8[i]);
            calc(m2[i], mode[i], a[i], b[i], 3,   n2[i], y2[i], h2[i]);
            chk("y_comb", i, 32'(y_c8[i]), 32'(act & y8[i]));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rst || clr) begin
                m8[i] = 0; m2[i] = 0; s8[i] = 0; s2[i] = 0; yr8[i] = 0; yr2[i] = 0;
            end else if (en) begin
                m8[i] = n8[i]; m2[i] = n2[i];
                s8[i] = s8[i] | h8[i]; s2[i] = s2[i] | h2[i];
                yr8[i] = y8[i]; yr2[i] = y2[i];
            end else begin
                yr8[i] = 0; yr2[i] = 0;
            end
            chk("count_r8", i, 32'(cnt_r8[i*8 +: 8]), 32'(m8[i]));
            chk("count_c8", i, 32'(cnt_c8[i*8 +: 8]), 32'(m8[i]));
            chk("sat_r8",   i, 32'(sat_r8[i]), 32'(s8[i]));
            chk("sat_c8",   i, 32'(sat_c8[i]), 32'(s8[i]));
            chk("y_r8",     i, 32'(y_r8[i]), 32'(yr8[i]));
            chk("count_r2", i, 32'(cnt_r2[i*2 +: 2]), 32'(m2[i]));
            chk("sat_r2",   i, 32'(sat_r2[i]), 32'(s2[i]));
            chk("y_r2",     i, 32'(y_r2[i]), 32'(yr2[i]));
        end
    endtask

    initial begin
        logic [3:0] sa;
        logic [3:0] sb;
        for (int i = 0; i < 4; i++) begin
            m8[i] = 0; m2[i] = 0; s8[i] = 0; s2[i] = 0; yr8[i] = 0; yr2[i] = 0;
        end

        // Reset with arbitrary inputs, then idle with EN low.
        drive(1, 1, 0, 4'($urandom), 4'($urandom), 4'($urandom));
        cycle();
        drive(1, 1, 0, 4'($urandom), 4'($urandom), 4'($urandom));
        cycle();
        chk("reset_count", 0, cnt_r8, 32'd0);
        chk("reset_sat",   0, 32'(sat_r8), 32'd0);
        drive(0, 0, 0, 4'($urandom), 4'($urandom), 4'($urandom));
        cycle();
        chk("idle_y", 0, 32'(y_r8), 32'd0);

        // Subtract on channel 0, including the zero floor.
        sa = 4'b1101; sb = 4'b0110;
        for (int k = 0; k < 7; k++) begin
            drive(0, 1, 0, 4'b0000, {3'b000, sa[k % 4]}, {3'b000, sb[k % 4]});
            if (k == 4) drive(0, 1, 0, 4'b0000, 4'b0000, 4'b0000);
            if (k == 5) drive(0, 1, 0, 4'b0000, 4'b0000, 4'b0001);
            if (k == 6) drive(0, 1, 0, 4'b0000, 4'b0001, 4'b0000);
            cycle();
        end
        chk("sub_floor_count", 0, 32'(cnt_r8[7:0]), 32'd0);
        chk("sub_last_y",      0, 32'(y_r8[0]),     32'd1);

        // Add on channel 1: build a backlog of 5 then drain.
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 4'b0010, 4'b0010, 4'b0010);
            cycle();
        end
        chk("add_build", 1, 32'(cnt_r8[15:8]), 32'd5);
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 0, 4'b0010, 4'b0000, 4'b0000);
            cycle();
        end
        chk("add_drain", 1, 32'(cnt_r8[15:8]), 32'd0);

        // Saturation of the 2-bit counters, sticky through a drain, then cleared.
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 4'b1111, 4'b1111, 4'b1111);
            cycle();
        end
        chk("sat_count", 0, 32'(cnt_r2[1:0]), 32'd3);
        chk("sat_flag",  0, 32'(sat_r2[0]),   32'd1);
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 4'b1111, 4'b0000, 4'b0000);
            cycle();
        end
        chk("sat_sticky", 0, 32'(sat_r2[0]), 32'd1);
        drive(0, 1, 1, 4'b1111, 4'b1111, 4'b1111);
        cycle();
        chk("clr_sat", 0, 32'(sat_r2), 32'd0);

        // Enable hold and mode switch with retained backlog.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 4'b1111, 4'b1111, 4'b1111);
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 4'b1111, 4'b1111, 4'b1111);
            cycle();
        end
        chk("hold_count", 0, 32'(cnt_r8[7:0]), 32'd3);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 4'b0000, 4'b0000, 4'b0000);
            cycle();
        end

        // Randomized traffic with occasional clear, disable and reset.
        for (int k = 0; k < 10000; k++) begin
            drive(($urandom_range(0, 255) == 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom), 4'($urandom));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
